// File: rtl/ls_commit_queue_pkg.sv
// Shared definitions for the load/store commit queue: default sizes,
// commit FSM encoding and the per-entry payload layout.
package ls_commit_queue_pkg;

  localparam int LSQ_ENTRIES_DEF = 16;
  localparam int LSQ_LEN_UID     = 8;
  localparam int LSQ_ADDR_W      = 32;
  localparam int LSQ_DATA_W      = 32;

  typedef enum logic [1:0] {
    LSQ_IDLE  = 2'd0,
    LSQ_ISSUE = 2'd1,
    LSQ_WAIT  = 2'd2
  } lsq_state_e;

  // UID is kept outside the struct because its width is a module parameter.
  typedef struct packed {
    logic                  valid;
    logic                  is_store;
    logic                  resolved;
    logic [LSQ_ADDR_W-1:0] addr;
    logic [LSQ_DATA_W-1:0] data;
  } lsq_entry_t;

  typedef struct packed {
    logic                  req;
    logic                  write;
    logic [LSQ_ADDR_W-1:0] addr;
    logic [LSQ_DATA_W-1:0] wdata;
  } lsq_mem_req_t;

endpackage

// File: rtl/ls_commit_queue_if.sv
// Core/memory-facing signal bundle of the commit queue. The queue itself
// uses the slave view; the surrounding core and memory use the master view.
interface ls_commit_queue_if #(
  parameter int LEN_UID = ls_commit_queue_pkg::LSQ_LEN_UID
);
  import ls_commit_queue_pkg::*;

  logic                  LS_NQ_IN;
  logic                  LS_IsStore_IN;
  logic [LEN_UID-1:0]    LS_UID_IN;
  logic                  AGU_Valid_IN;
  logic [LEN_UID-1:0]    AGU_UID_IN;
  logic [LSQ_ADDR_W-1:0] AGU_Addr_IN;
  logic [LSQ_DATA_W-1:0] AGU_Data_IN;
  logic                  LS_Retire_IN;
  logic                  LS_Retire_Ready_OUT;
  logic                  Recover_IN;
  logic                  LSQ_full_OUT;
  logic                  LSQ_empty_OUT;
  logic                  MEM_Req_OUT;
  logic                  MEM_Write_OUT;
  logic [LSQ_ADDR_W-1:0] MEM_Addr_OUT;
  logic [LSQ_DATA_W-1:0] MEM_WData_OUT;
  logic                  MEM_Ack_IN;
  logic [LSQ_DATA_W-1:0] MEM_RData_IN;
  logic                  LoadDone_OUT;
  logic [LEN_UID-1:0]    LoadUID_OUT;
  logic [LSQ_DATA_W-1:0] LoadData_OUT;

  modport slave (
    input  LS_NQ_IN, LS_IsStore_IN, LS_UID_IN,
    input  AGU_Valid_IN, AGU_UID_IN, AGU_Addr_IN, AGU_Data_IN,
    input  LS_Retire_IN, Recover_IN, MEM_Ack_IN, MEM_RData_IN,
    output LS_Retire_Ready_OUT, LSQ_full_OUT, LSQ_empty_OUT,
    output MEM_Req_OUT, MEM_Write_OUT, MEM_Addr_OUT, MEM_WData_OUT,
    output LoadDone_OUT, LoadUID_OUT, LoadData_OUT
  );

  modport master (
    output LS_NQ_IN, LS_IsStore_IN, LS_UID_IN,
    output AGU_Valid_IN, AGU_UID_IN, AGU_Addr_IN, AGU_Data_IN,
    output LS_Retire_IN, Recover_IN, MEM_Ack_IN, MEM_RData_IN,
    input  LS_Retire_Ready_OUT, LSQ_full_OUT, LSQ_empty_OUT,
    input  MEM_Req_OUT, MEM_Write_OUT, MEM_Addr_OUT, MEM_WData_OUT,
    input  LoadDone_OUT, LoadUID_OUT, LoadData_OUT
  );

endinterface

// File: rtl/ls_commit_queue_cam.sv
// lsq_cam: UID match across all queue entries for AGU resolution.
// UID 0 is reserved as "no instruction" and never matches.
module lsq_cam
  import ls_commit_queue_pkg::*;
#(
  parameter int ENTRIES = LSQ_ENTRIES_DEF,
  parameter int LEN_UID = LSQ_LEN_UID
) (
  input  logic [ENTRIES-1:0] valid_i,
  input  logic [LEN_UID-1:0] uid_i [ENTRIES],
  input  logic               lookup_valid_i,
  input  logic [LEN_UID-1:0] lookup_uid_i,
  output logic [ENTRIES-1:0] hit_o
);

  always_comb begin
    hit_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_o[i] = lookup_valid_i && (lookup_uid_i != '0) && valid_i[i] &&
                 (uid_i[i] == lookup_uid_i);
    end
  end

endmodule

// File: rtl/ls_commit_queue.sv
// In-order load/store commit queue: ops enqueue in program order, get their
// address/data from the AGU, and are sent to memory one at a time on retire.
module ls_commit_queue
  import ls_commit_queue_pkg::*;
#(
  parameter int LSQ_ENTRIES = LSQ_ENTRIES_DEF,
  parameter int LEN_UID     = LSQ_LEN_UID
) (
  input  logic             CLK,
  input  logic             RESET,
  ls_commit_queue_if.slave bus
);

  localparam int PW = $clog2(LSQ_ENTRIES);

  lsq_state_e         state_q;
  logic [PW-1:0]      head_q, head_d;
  logic [PW-1:0]      tail_q, tail_d;
  logic [PW-1:0]      head_inc, tail_inc;
  lsq_entry_t         ent_q [LSQ_ENTRIES];
  logic [LEN_UID-1:0] uid_q [LSQ_ENTRIES];
  lsq_mem_req_t       mem_q;
  logic               load_done_q;
  logic [LEN_UID-1:0] load_uid_q;
  logic [31:0]        load_data_q;

  logic               empty, full, ready;
  logic               commit, enq, deq;
  logic [LSQ_ENTRIES-1:0] valid_vec;
  logic [LSQ_ENTRIES-1:0] cam_hit;

  assign head_inc = head_q + PW'(1);
  assign tail_inc = tail_q + PW'(1);
  assign empty    = (head_q == tail_q);
  assign full     = (tail_inc == head_q);

  // Readiness looks only at registered state, so an AGU write to the head in
  // the retire cycle cannot make that same retire succeed.
  assign ready  = (state_q == LSQ_IDLE) && !empty &&
                  ent_q[head_q].valid && ent_q[head_q].resolved;
  assign commit = bus.LS_Retire_IN && ready && !bus.Recover_IN;
  assign enq    = bus.LS_NQ_IN && !full && !bus.Recover_IN;
  assign deq    = (state_q == LSQ_WAIT) && bus.MEM_Ack_IN;

  always_comb begin
    for (int i = 0; i < LSQ_ENTRIES; i++) begin
      valid_vec[i] = ent_q[i].valid;
    end
  end

  lsq_cam #(
    .ENTRIES (LSQ_ENTRIES),
    .LEN_UID (LEN_UID)
  ) u_cam (
    .valid_i        (valid_vec),
    .uid_i          (uid_q),
    .lookup_valid_i (bus.AGU_Valid_IN),
    .lookup_uid_i   (bus.AGU_UID_IN),
    .hit_o          (cam_hit)
  );

  // A flush keeps only the op already handed to memory, if there is one.
  always_comb begin
    head_d = deq ? head_inc : head_q;
    tail_d = tail_q;
    if (bus.Recover_IN) begin
      tail_d = (state_q == LSQ_IDLE) ? head_q : head_inc;
    end else if (enq) begin
      tail_d = tail_inc;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < LSQ_ENTRIES; i++) begin
        ent_q[i] <= '0;
        uid_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LSQ_ENTRIES; i++) begin
        if (cam_hit[i]) begin
          ent_q[i].addr     <= bus.AGU_Addr_IN;
          ent_q[i].data     <= bus.AGU_Data_IN;
          ent_q[i].resolved <= 1'b1;
        end
        if (bus.Recover_IN && !((state_q != LSQ_IDLE) && (PW'(i) == head_q))) begin
          ent_q[i].valid <= 1'b0;
        end
      end
      if (enq) begin
        ent_q[tail_q] <= '{valid: 1'b1, is_store: bus.LS_IsStore_IN,
                           resolved: 1'b0, addr: '0, data: '0};
        uid_q[tail_q] <= bus.LS_UID_IN;
      end
      if (deq) begin
        ent_q[head_q].valid <= 1'b0;
      end
    end
  end

  // Commit FSM; memory request fields are latched at commit and stay
  // frozen through ISSUE and WAIT.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= LSQ_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      mem_q       <= '0;
      load_done_q <= 1'b0;
      load_uid_q  <= '0;
      load_data_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      load_done_q <= 1'b0;
      case (state_q)
        LSQ_IDLE: begin
          if (commit) begin
            state_q     <= LSQ_ISSUE;
            mem_q.req   <= 1'b1;
            mem_q.write <= ent_q[head_q].is_store;
            mem_q.addr  <= ent_q[head_q].addr;
            mem_q.wdata <= ent_q[head_q].data;
          end
        end
        LSQ_ISSUE: begin
          state_q <= LSQ_WAIT;
        end
        LSQ_WAIT: begin
          if (bus.MEM_Ack_IN) begin
            state_q     <= LSQ_IDLE;
            mem_q.req   <= 1'b0;
            mem_q.write <= 1'b0;
            if (!ent_q[head_q].is_store) begin
              load_done_q <= 1'b1;
              load_uid_q  <= uid_q[head_q];
              load_data_q <= bus.MEM_RData_IN;
            end
          end
        end
        default: begin
          state_q <= LSQ_IDLE;
        end
      endcase
    end
  end

  assign bus.LS_Retire_Ready_OUT = ready;
  assign bus.LSQ_full_OUT        = full;
  assign bus.LSQ_empty_OUT       = empty;
  assign bus.MEM_Req_OUT         = mem_q.req;
  assign bus.MEM_Write_OUT       = mem_q.write;
  assign bus.MEM_Addr_OUT        = mem_q.addr;
  assign bus.MEM_WData_OUT       = mem_q.wdata;
  assign bus.LoadDone_OUT        = load_done_q;
  assign bus.LoadUID_OUT         = load_uid_q;
  assign bus.LoadData_OUT        = load_data_q;

endmodule

// File: tb/tb_ls_commit_queue.sv
// Bench for ls_commit_queue: directed scenarios plus random traffic, all
// checked every cycle against a queue-level reference model.
module tb_ls_commit_queue;
  import ls_commit_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int UW    = LSQ_LEN_UID;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ls_commit_queue_if #(.LEN_UID(UW)) bus();

  ls_commit_queue #(
    .LSQ_ENTRIES (DEPTH),
    .LEN_UID     (UW)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          isStore;
    logic [UW-1:0] uid;
    bit          resolved;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    bit          nq;
    bit          isStore;
    logic [UW-1:0] uid;
    bit          aguV;
    logic [UW-1:0] aguUid;
    logic [31:0] aguAddr;
    logic [31:0] aguData;
    bit          retire;
    bit          recover;
    bit          ack;
    logic [31:0] rdata;
  } stim_t;

  // Reference model: program-order list of live ops plus the op in memory.
  op_t           mq[$];
  bit            busy;
  int            age;
  op_t           cur;
  bit            expLoad;
  logic [UW-1:0] expLoadUid;
  logic [31:0]   expLoadData;

  int            total = 0;
  int            bad = 0;
  int            memWrites;
  logic [31:0]   lastWAddr, lastWData;
  int            loadCnt;
  logic [UW-1:0] lastLoadUid;
  logic [31:0]   lastLoadData;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.nq = 0; s.isStore = 0; s.uid = '0;
    s.aguV = 0; s.aguUid = '0; s.aguAddr = '0; s.aguData = '0;
    s.retire = 0; s.recover = 0; s.ack = 0; s.rdata = '0;
    return s;
  endfunction

  task automatic driveInputs(input stim_t s);
    bus.LS_NQ_IN      = s.nq;
    bus.LS_IsStore_IN = s.isStore;
    bus.LS_UID_IN     = s.uid;
    bus.AGU_Valid_IN  = s.aguV;
    bus.AGU_UID_IN    = s.aguUid;
    bus.AGU_Addr_IN   = s.aguAddr;
    bus.AGU_Data_IN   = s.aguData;
    bus.LS_Retire_IN  = s.retire;
    bus.Recover_IN    = s.recover;
    bus.MEM_Ack_IN    = s.ack;
    bus.MEM_RData_IN  = s.rdata;
  endtask

  task automatic clearModel();
    mq.delete();
    busy = 0; age = 0; expLoad = 0;
    expLoadUid = '0; expLoadData = '0;
  endtask

  // One clock: drive, advance the model by the rules, clock, compare.
  task automatic applyStimulus(input stim_t s);
    bit readyNow, commit, deq, wasBusy, expReady;
    int preSize;
    op_t t;
    driveInputs(s);
    wasBusy  = busy;
    preSize  = mq.size();
    readyNow = !busy && preSize > 0 && mq[0].resolved;
    commit   = s.retire && readyNow && !s.recover;
    deq      = busy && age >= 1 && s.ack;
    if (deq && bus.MEM_Req_OUT && bus.MEM_Write_OUT) begin
      memWrites++;
      lastWAddr = bus.MEM_Addr_OUT;
      lastWData = bus.MEM_WData_OUT;
    end
    expLoad = 0;
    if (commit) begin
      cur = mq[0]; busy = 1; age = 0;
    end else if (busy) begin
      age++;
    end
    if (s.aguV && s.aguUid != '0) begin
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].uid == s.aguUid) begin
          t = mq[i];
          t.resolved = 1; t.addr = s.aguAddr; t.data = s.aguData;
          mq[i] = t;
        end
      end
    end
    if (deq) begin
      if (!cur.isStore) begin
        expLoad = 1; expLoadUid = cur.uid; expLoadData = s.rdata;
      end
      void'(mq.pop_front());
      busy = 0;
    end
    if (s.recover) begin
      if (wasBusy && !deq) begin
        while (mq.size() > 1) void'(mq.pop_back());
      end else begin
        mq.delete();
      end
    end
    if (s.nq && !s.recover && preSize < DEPTH - 1) begin
      t.isStore = s.isStore; t.uid = s.uid; t.resolved = 0;
      t.addr = '0; t.data = '0;
      mq.push_back(t);
    end
    @(posedge clk);
    #1;
    if (bus.LoadDone_OUT) begin
      loadCnt++;
      lastLoadUid  = bus.LoadUID_OUT;
      lastLoadData = bus.LoadData_OUT;
    end
    expReady = !busy && mq.size() > 0 && mq[0].resolved;
    checkOutput("ready", bus.LS_Retire_Ready_OUT, expReady);
    checkOutput("full", bus.LSQ_full_OUT, mq.size() == DEPTH - 1);
    checkOutput("empty", bus.LSQ_empty_OUT, mq.size() == 0);
    checkOutput("memReq", bus.MEM_Req_OUT, busy);
    checkOutput("memWrite", bus.MEM_Write_OUT, busy && cur.isStore);
    if (busy) begin
      checkOutput("memAddr", bus.MEM_Addr_OUT, cur.addr);
      checkOutput("memWData", bus.MEM_WData_OUT, cur.data);
    end
    checkOutput("loadDone", bus.LoadDone_OUT, expLoad);
    if (expLoad) begin
      checkOutput("loadUid", 32'(bus.LoadUID_OUT), 32'(expLoadUid));
      checkOutput("loadData", bus.LoadData_OUT, expLoadData);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Req"},   bus.MEM_Req_OUT, 0);
    checkOutput({tag, "Write"}, bus.MEM_Write_OUT, 0);
    checkOutput({tag, "Addr"},  bus.MEM_Addr_OUT, 0);
    checkOutput({tag, "WData"}, bus.MEM_WData_OUT, 0);
    checkOutput({tag, "LDone"}, bus.LoadDone_OUT, 0);
    checkOutput({tag, "LUid"},  32'(bus.LoadUID_OUT), 0);
    checkOutput({tag, "LData"}, bus.LoadData_OUT, 0);
    checkOutput({tag, "Empty"}, bus.LSQ_empty_OUT, 1);
    checkOutput({tag, "Full"},  bus.LSQ_full_OUT, 0);
    checkOutput({tag, "Ready"}, bus.LS_Retire_Ready_OUT, 0);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    driveInputs(idleStim());
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("rst");
    clearModel();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic doEnq(input bit isStore, input int uid);
    stim_t s = idleStim();
    s.nq = 1; s.isStore = isStore; s.uid = UW'(uid);
    applyStimulus(s);
  endtask

  task automatic doAgu(input int uid, input logic [31:0] addr, input logic [31:0] data);
    stim_t s = idleStim();
    s.aguV = 1; s.aguUid = UW'(uid); s.aguAddr = addr; s.aguData = data;
    applyStimulus(s);
  endtask

  task automatic doRetire();
    stim_t s = idleStim();
    s.retire = 1;
    applyStimulus(s);
  endtask

  task automatic doAck(input logic [31:0] rdata);
    stim_t s = idleStim();
    s.ack = 1; s.rdata = rdata;
    applyStimulus(s);
  endtask

  task automatic doRecover();
    stim_t s = idleStim();
    s.recover = 1;
    applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    resetDut();

    // Store commit with the ack three cycles after retire.
    memWrites = 0;
    doEnq(1, 5);
    doAgu(5, 32'h100, 32'hDEAD);
    doRetire();
    checkOutput("stIssueReq", bus.MEM_Req_OUT, 1);
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    doAck(32'h0);
    checkOutput("stWrites", memWrites, 1);
    checkOutput("stWAddr", lastWAddr, 32'h100);
    checkOutput("stWData", lastWData, 32'hDEAD);
    checkOutput("stEmpty", bus.LSQ_empty_OUT, 1);

    // Load commit.
    loadCnt = 0;
    doEnq(0, 7);
    doAgu(7, 32'h200, 32'h0);
    doRetire();
    applyStimulus(idleStim());
    doAck(32'h1234);
    checkOutput("ldCount", loadCnt, 1);
    checkOutput("ldUid", 32'(lastLoadUid), 7);
    checkOutput("ldData", lastLoadData, 32'h1234);
    applyStimulus(idleStim());
    checkOutput("ldPulse", bus.LoadDone_OUT, 0);

    // Fill, overfill, drain, refill across the pointer wrap.
    for (int i = 1; i <= 15; i++) doEnq(1, i);
    checkOutput("full15", bus.LSQ_full_OUT, 1);
    doEnq(1, 99);
    checkOutput("full16", bus.LSQ_full_OUT, 1);
    for (int i = 1; i <= 15; i++) doAgu(i, 32'h1000 + 32'(i), 32'hA000 + 32'(i));
    for (int i = 1; i <= 15; i++) begin
      doRetire();
      applyStimulus(idleStim());
      doAck(32'h0);
    end
    checkOutput("drainEmpty", bus.LSQ_empty_OUT, 1);
    for (int i = 1; i <= 15; i++) doEnq(0, 20 + i);
    checkOutput("wrapFull", bus.LSQ_full_OUT, 1);
    doRecover();
    checkOutput("wrapFlush", bus.LSQ_empty_OUT, 1);

    // Recover while the head is waiting on memory.
    for (int i = 1; i <= 4; i++) doEnq(0, 40 + i);
    for (int i = 1; i <= 4; i++) doAgu(40 + i, 32'h300 + 32'(i), 32'h0);
    doRetire();
    applyStimulus(idleStim());
    doRecover();
    checkOutput("rcvHeadLive", bus.LSQ_empty_OUT, 0);
    checkOutput("rcvReqHeld", bus.MEM_Req_OUT, 1);
    doAck(32'h55AA);
    checkOutput("rcvEmpty", bus.LSQ_empty_OUT, 1);

    // Retire against an unresolved head.
    doEnq(0, 9);
    doRetire();
    checkOutput("unrReady", bus.LS_Retire_Ready_OUT, 0);
    checkOutput("unrReq", bus.MEM_Req_OUT, 0);
    // AGU resolving the head in the retire cycle must not let that retire through.
    s = idleStim();
    s.retire = 1; s.aguV = 1; s.aguUid = UW'(9); s.aguAddr = 32'h900;
    applyStimulus(s);
    checkOutput("sameCycReq", bus.MEM_Req_OUT, 0);
    doRecover();

    // Asynchronous reset while a store sits in ISSUE.
    doEnq(1, 3);
    doAgu(3, 32'h400, 32'hBEEF);
    doRetire();
    checkOutput("preRstReq", bus.MEM_Req_OUT, 1);
    rst_n = 1'b0;
    #2;
    checkResetOutputs("async");
    resetDut();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      s = idleStim();
      s.nq      = ($urandom_range(0, 99) < 50);
      s.isStore = $urandom_range(0, 1);
      s.uid     = UW'($urandom_range(0, 12));
      s.aguV    = ($urandom_range(0, 99) < 45);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        s.aguUid = mq[$urandom_range(0, mq.size() - 1)].uid;
      else
        s.aguUid = UW'($urandom_range(0, 12));
      s.aguAddr = $urandom;
      s.aguData = $urandom;
      s.recover = ($urandom_range(0, 99) < 3);
      s.retire  = !s.recover && ($urandom_range(0, 99) < 40);
      s.ack     = ($urandom_range(0, 99) < 50);
      s.rdata   = $urandom;
      applyStimulus(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ls_commit_queue.md
LS_COMMIT_QUEUE -- requirements
Module: ls_commit_queue

Interface
REQ-001 Parameters: LSQ_ENTRIES, default 16, queue depth (power of two); LEN_UID, default `LEN_UID, instruction UID width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low. Ports: CLK in 1, clock; RESET in 1, asynchronous active-low reset.
REQ-003 Ports:
- LS_NQ_IN in 1: enqueue in program order.
- LS_IsStore_IN in 1: 1 = store, 0 = load.
- LS_UID_IN in LEN_UID: UID of the enqueued op.
- AGU_Valid_IN in 1, AGU_UID_IN in LEN_UID, AGU_Addr_IN in 32, AGU_Data_IN in 32: address/store-data resolution.
- LS_Retire_IN in 1: commit pulse from the ROB retire stage.
- LS_Retire_Ready_OUT out 1: queue can accept a commit.
- Recover_IN in 1: misprediction flush.
- LSQ_full_OUT out 1, LSQ_empty_OUT out 1.
- MEM_Req_OUT out 1, MEM_Write_OUT out 1, MEM_Addr_OUT out 32, MEM_WData_OUT out 32, MEM_Ack_IN in 1, MEM_RData_IN in 32: data-memory port.
- LoadDone_OUT out 1, LoadUID_OUT out LEN_UID, LoadData_OUT out 32: load writeback.

Function
REQ-004 Storage: circular buffer of LSQ_ENTRIES entries {valid, is_store, uid, addr, data, resolved}, with head/tail pointers of log2(LSQ_ENTRIES) bits that wrap modulo depth.
REQ-005 Full/empty: full = (tail+1)==head; empty = head==tail. One slot stays unused.
REQ-006 Enqueue: LS_NQ_IN high and not full writes the tail entry with resolved=0 and advances tail next edge. LS_NQ_IN while full is dropped and the queue is unchanged.
REQ-007 Resolution: AGU_Valid_IN writes addr/data and sets resolved=1 in every valid entry whose uid matches AGU_UID_IN (CAM); UID 0 never matches.
REQ-008 Ready: LS_Retire_Ready_OUT = state IDLE and not empty and head resolved (combinational).
REQ-009 FSM states: IDLE, ISSUE, WAIT.
- IDLE -> ISSUE on LS_Retire_IN while ready.
- ISSUE drives MEM_Req_OUT=1 with MEM_Write_OUT=head is_store and head addr/data, then -> WAIT.
- WAIT holds all MEM_* outputs stable until MEM_Ack_IN, then dequeues the head (head+1) and -> IDLE.
REQ-010 Retire without ready: LS_Retire_IN while not ready is ignored; no state change.
REQ-011 Loads: on MEM_Ack_IN for a load, LoadDone_OUT pulses 1 cycle with head uid and MEM_RData_IN. Stores produce no writeback.
REQ-012 Latency: commit-to-request 1 cycle; earliest dequeue 2 cycles after the commit; back-to-back commits at most every 3 cycles.
REQ-013 Recover_IN:
- Sets tail = head, or head+1 when state is not IDLE.
- Clears the valid bits of every flushed entry.
- Any in-flight memory operation finishes normally.
REQ-014 Simultaneous events:
- Recover_IN beats LS_NQ_IN in the same cycle (the enqueue is dropped).
- An enqueue and a dequeue in the same cycle are both performed.
- AGU resolution of the head in the cycle of LS_Retire_IN does not make that commit valid.

Reset
REQ-015 RESET low, asynchronously: state=IDLE, head=tail=0, all valid=0, MEM_Req_OUT=0, MEM_Write_OUT=0, LoadDone_OUT=0, MEM_Addr_OUT/MEM_WData_OUT/LoadUID_OUT/LoadData_OUT=0, LSQ_empty_OUT=1, LSQ_full_OUT=0.
REQ-016 Reset asserted mid-transaction abandons the operation. The memory side must tolerate a request that drops before its ack.

Structure
REQ-017 Entry field offsets, the LEN_UID width and FSM state encodings belong in the shared const.v/config.v definitions.
REQ-018 One sub-module, lsq_cam, implements the UID match/update across entries.

Verification
REQ-019 Store commit:
- Stimulus: enqueue store uid 5; AGU uid 5 addr 0x100 data 0xDEAD; LS_Retire pulse; ack 3 cycles later.
- Response: exactly one write of 0xDEAD to 0x100; queue empty afterwards.
REQ-020 Load commit:
- Stimulus: enqueue load uid 7 at addr 0x200; commit; ack with MEM_RData_IN 0x1234.
- Response: LoadDone pulse with uid 7 and data 0x1234.
REQ-021 Full and wrap:
- Stimulus: 15 enqueues; 16th enqueue; commit 15 entries; then 15 more enqueues.
- Response: LSQ_full_OUT=1 after the 15th enqueue; the 16th is dropped; pointers wrap correctly.
REQ-022 Recover mid-WAIT:
- Stimulus: 4 entries queued, head in WAIT, assert Recover_IN.
- Response: head op completes; then empty=1.
REQ-023 Unresolved head:
- Stimulus: LS_Retire_IN while the head is unresolved.
- Response: Ready=0 and no MEM_Req_OUT.
REQ-024 Async reset:
- Stimulus: RESET low during ISSUE.
- Response: all outputs reach their REQ-015 values without waiting for a clock edge.
